mp3_sci_reader: RTL and testbench
=================================

Name: mp3_sci_reader

Overview:
- SCI read engine for the VS10xx MP3 decoder; the read-side counterpart of the existing SCI/SDI write path.
- Issues READ (opcode 0x03) + register address on SI, then shifts the 16-bit register value in on SO, MSB first.
- Typical targets: SCI_DECODE_TIME and SCI_STATUS, used for the play-time display and health checks.
- Shares XCS/SCK/SI with the writer; an external mux hands these pins to this block while busy=1.

Parameters:
- READ_OPCODE, 8'h03, SCI read instruction byte.
- DREQ_TIMEOUT, 50000, clk_1M cycles to wait for DREQ high before aborting.

Ports:
- clk_1M  in  1  1 MHz system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- rd_req  in  1  read request, sampled only in IDLE.
- rd_addr  in  4  SCI register address, latched on acceptance.
- DREQ  in  1  decoder ready, active high.
- SO  in  1  serial data from the decoder.
- XCS  out  1  SCI chip select, active low.
- SCK  out  1  serial clock to the decoder.
- SI  out  1  serial data to the decoder.
- rd_data  out  16  last register value read; held until the next read completes.
- rd_valid  out  1  one-cycle pulse when rd_data updates.
- busy  out  1  high from acceptance until return to IDLE.
- timeout_err  out  1  one-cycle pulse on DREQ timeout.

Behaviour:
- Reset (rst=0 at an edge): XCS=1, SCK=0, SI=0, rd_data=0, rd_valid=0, busy=0, timeout_err=0, state=IDLE, counters=0.
  - Applies from any state, including mid-frame; the frame is abandoned and no rd_valid is issued.
- All outputs are registered. The frame word is {READ_OPCODE, 4'h0, rd_addr}, shifted MSB first.
- IDLE:
  - On rd_req=1: latch rd_addr, busy<=1, clear timeout counter, go WAIT_DREQ.
  - On rd_req=0: stay.
- WAIT_DREQ:
  - If DREQ=1: XCS<=0, SCK<=0, SI<=frame[15], go SHIFT_OUT.
  - Else, if the counter equals DREQ_TIMEOUT-1: timeout_err<=1 for one cycle, busy<=0, go IDLE. XCS never asserts in this case.
  - Else: increment the counter.
- SHIFT_OUT (16 bits, 2 cycles/bit, SCK = clk_1M/2):
  - SCK=0 edge: SCK<=1; decoder samples SI on this rise.
  - SCK=1 edge: SCK<=0 and SI<=next bit.
  - After the 16th high phase: SCK<=0, SI<=0, go SHIFT_IN.
  - DREQ is ignored from here to frame end.
- SHIFT_IN (16 bits):
  - SCK=0 edge: SCK<=1.
  - SCK=1 edge: shreg<={shreg[14:0],SO}, SCK<=0. SO is captured at the end of the high phase; the decoder updates SO on falling SCK.
  - The 16th capture also sets XCS<=1 and goes FINISH.
- FINISH: rd_data<=shreg, rd_valid<=1 (one cycle), busy<=0, go IDLE.
- Latency with DREQ already high, edge 0 = rd_req capture:
  - Edge 1: XCS low, SI = bit 15.
  - Edges 2..32: address/opcode bits.
  - Edge 33: enter SHIFT_IN.
  - SO captures at edges 35, 37, ..., 65; XCS high at edge 65.
  - rd_valid high after edge 66.
- Each frame produces exactly 32 SCK rising edges: 16 out + 16 in.
- rd_req while busy=1 is ignored, not queued. After rd_valid, a new request is accepted on the next edge.
- rd_req on the same edge as timeout_err is ignored; the block is in IDLE on the following edge.

Test Plan:
- Decoder model returns 0x1234 for addr 4, DREQ=1, rd_req pulse -> SI stream 0x0304; 32 SCK rises; XCS low from edge 1 through edge 65; rd_data=0x1234; rd_valid one cycle after edge 66; busy 1→0 at that edge.
- DREQ held low 100 cycles after rd_req, then high -> XCS stays 1 for 100 cycles; frame starts the edge after DREQ rises; timing is otherwise identical to the first scenario.
- DREQ_TIMEOUT=1000, DREQ stuck low -> timeout_err pulses once after 1000 wait cycles; XCS/SCK never toggle; busy=0; rd_data unchanged.
- rd_req held high throughout, addr=0xF, model data 0xFFFF then 0x0000 -> back-to-back frames; second rd_req ignored while busy; rd_data=0xFFFF then 0x0000; each rd_valid exactly 1 cycle.
- rst=0 asserted at edge 45 (mid SHIFT_IN) -> next edge XCS=1, SCK=0, busy=0; no rd_valid; rd_data=0; a fresh read after reset returns the correct value.

Source files
------------

// File: rtl/mp3_sci_reader_if.sv
// Host request/response and VS10xx SCI pin bundle
// for the SCI read engine.
interface mp3_sci_reader_if;
  logic        rd_req;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        timeout_err;
  logic        DREQ;
  logic        SO;
  logic        XCS;
  logic        SCK;
  logic        SI;

  modport slave (
    input  rd_req, rd_addr, DREQ, SO,
    output rd_data, rd_valid, busy, timeout_err,
    output XCS, SCK, SI
  );

  modport master (
    output rd_req, rd_addr, DREQ, SO,
    input  rd_data, rd_valid, busy, timeout_err,
    input  XCS, SCK, SI
  );
endinterface

// File: rtl/mp3_sci_reader.sv
// VS10xx SCI read engine: sends READ + address on SI,
// then shifts the 16-bit register value in from SO.
module mp3_sci_reader #(
  parameter logic [7:0] READ_OPCODE  = 8'h03,
  parameter int         DREQ_TIMEOUT = 50000
) (
  input  logic clk_1M,
  input  logic rst,
  mp3_sci_reader_if.slave bus
);

  localparam int CW = (DREQ_TIMEOUT > 1) ? $clog2(DREQ_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(DREQ_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DREQ,
    SHIFT_OUT,
    SHIFT_IN,
    FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    addr_q, addr_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   shreg_q, shreg_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          busy_q, busy_d;
  logic          tmo_err_q, tmo_err_d;
  logic          xcs_q, xcs_d;
  logic          sck_q, sck_d;
  logic          si_q, si_d;
  logic [15:0]   frame;

  assign frame = {READ_OPCODE, 4'h0, addr_q};

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tmo_d      = tmo_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    busy_d     = busy_q;
    tmo_err_d  = 1'b0;
    xcs_d      = xcs_q;
    sck_d      = sck_q;
    si_d       = si_q;
    unique case (state_q)
      IDLE: begin
        if (bus.rd_req) begin
          addr_d  = bus.rd_addr;
          busy_d  = 1'b1;
          tmo_d   = '0;
          state_d = WAIT_DREQ;
        end
      end
      WAIT_DREQ: begin
        if (bus.DREQ) begin
          xcs_d   = 1'b0;
          sck_d   = 1'b0;
          si_d    = frame[15];
          shreg_d = {frame[14:0], 1'b0};
          bit_d   = 4'd0;
          state_d = SHIFT_OUT;
        end else if (tmo_q == TMO_LAST) begin
          tmo_err_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      SHIFT_OUT: begin
        if (!sck_q) begin
          sck_d = 1'b1;
        end else begin
          sck_d = 1'b0;
          if (bit_q == 4'd15) begin
            si_d    = 1'b0;
            bit_d   = 4'd0;
            state_d = SHIFT_IN;
          end else begin
            si_d    = shreg_q[15];
            shreg_d = {shreg_q[14:0], 1'b0};
            bit_d   = bit_q + 4'd1;
          end
        end
      end
      SHIFT_IN: begin
        // SO is taken at the end of the high phase; the
        // decoder only moves it on the falling edge.
        if (!sck_q) begin
          sck_d = 1'b1;
        end else begin
          sck_d   = 1'b0;
          shreg_d = {shreg_q[14:0], bus.SO};
          if (bit_q == 4'd15) begin
            xcs_d   = 1'b1;
            bit_d   = 4'd0;
            state_d = FINISH;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      FINISH: begin
        rd_data_d  = shreg_q;
        rd_valid_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_1M) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      tmo_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      tmo_err_q  <= 1'b0;
      xcs_q      <= 1'b1;
      sck_q      <= 1'b0;
      si_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tmo_q      <= tmo_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      tmo_err_q  <= tmo_err_d;
      xcs_q      <= xcs_d;
      sck_q      <= sck_d;
      si_q       <= si_d;
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = tmo_err_q;
  assign bus.XCS         = xcs_q;
  assign bus.SCK         = sck_q;
  assign bus.SI          = si_q;

endmodule

// File: tb/tb_mp3_sci_reader.sv
// Bench for mp3_sci_reader: VS10xx SCI slave model,
// read vector table and hand-written corner sequences.
module tb_mp3_sci_reader;

  logic clk_1M = 1'b0;
  logic rst    = 1'b0;

  always #5 clk_1M = ~clk_1M;

  mp3_sci_reader_if bus();

  mp3_sci_reader #(
    .READ_OPCODE (8'h03),
    .DREQ_TIMEOUT(1000)
  ) dut (
    .clk_1M(clk_1M),
    .rst   (rst),
    .bus   (bus)
  );

  // decoder model
  logic [15:0] mem [16];
  int          rise_cnt    = 0;
  int          frame_rises = 0;
  int          stray       = 0;
  logic [15:0] si_word     = '0;
  logic [15:0] frame_si    = '0;
  logic        so_m        = 1'b0;
  logic        sck_p       = 1'b0;
  logic        xcs_p       = 1'b1;

  assign bus.SO = so_m;

  always @(bus.SCK or bus.XCS) begin
    if (bus.XCS !== xcs_p) begin
      if (bus.XCS === 1'b0) begin
        rise_cnt = 0;
        si_word  = '0;
      end else if (bus.XCS === 1'b1) begin
        frame_rises = rise_cnt;
        frame_si    = si_word;
      end
      xcs_p = bus.XCS;
    end
    if (bus.SCK !== sck_p) begin
      if (bus.SCK === 1'b1) begin
        if (bus.XCS !== 1'b0) begin
          stray++;
        end else begin
          if (rise_cnt < 16) si_word = {si_word[14:0], bus.SI};
          rise_cnt++;
        end
      end else if (bus.XCS === 1'b0 && rise_cnt >= 16 && rise_cnt < 32) begin
        so_m = mem[si_word[3:0]][4'(31 - rise_cnt)];
      end
      sck_p = bus.SCK;
    end
  end

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    int          delay;
    logic [15:0] si;
  } vec_t;

  vec_t        vecs [4];
  logic [15:0] sb_q [$];
  logic [15:0] last_exp;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_1M);
    #1;
    cyc++;
  endtask

  task automatic req(input logic [3:0] a, output int rc);
    bus.rd_addr = a;
    bus.rd_req  = 1'b1;
    tick();
    rc = cyc;
    bus.rd_req = 1'b0;
  endtask

  task automatic do_frame(input int rc, input int exp_start,
                          input logic [15:0] exp_si);
    int start = -1;
    int vld   = -1;
    int lows  = 0;
    for (int i = 0; i < 2000 && vld < 0; i++) begin
      tick();
      if (bus.XCS === 1'b0) begin
        lows++;
        if (start < 0) start = cyc;
      end
      if (bus.rd_valid === 1'b1) vld = cyc;
    end
    chk("valid_seen", 32'(vld >= 0), 1);
    chk("start_lat", start - rc, exp_start);
    chk("frame_len", vld - start, 65);
    chk("xcs_low", lows, 64);
    chk("sck_rises", frame_rises, 32);
    chk("si_word", frame_si, exp_si);
    chk("busy_drop", bus.busy, 0);
    chk("sb_size", 32'(sb_q.size() > 0), 1);
    if (sb_q.size() > 0) chk("rd_data", bus.rd_data, sb_q.pop_front());
  endtask

  initial begin
    int rc;
    int lows;
    int te;
    int st0;
    int vcnt;

    vecs[0] = '{4'h4, 16'h1234, 0,   16'h0304};
    vecs[1] = '{4'hB, 16'hA5C3, 0,   16'h030B};
    vecs[2] = '{4'h4, 16'h8001, 100, 16'h0304};
    vecs[3] = '{4'h0, 16'h5A5A, 3,   16'h0300};

    bus.rd_req  = 1'b0;
    bus.rd_addr = 4'h0;
    bus.DREQ    = 1'b0;
    last_exp    = 16'h0000;

    // reset state
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_xcs", bus.XCS, 1);
    chk("rst_sck", bus.SCK, 0);
    chk("rst_si", bus.SI, 0);
    chk("rst_data", bus.rd_data, 0);
    chk("rst_valid", bus.rd_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tmo", bus.timeout_err, 0);
    rst = 1'b1;
    tick();

    // vector table
    for (int i = 0; i < 4; i++) begin
      mem[vecs[i].addr] = vecs[i].data;
      sb_q.push_back(vecs[i].data);
      bus.DREQ = (vecs[i].delay == 0);
      req(vecs[i].addr, rc);
      chk("busy_set", bus.busy, 1);
      lows = 0;
      for (int k = 0; k < vecs[i].delay; k++) begin
        tick();
        if (bus.XCS !== 1'b1) lows++;
      end
      bus.DREQ = 1'b1;
      chk("xcs_wait", lows, 0);
      do_frame(rc, vecs[i].delay + 1, vecs[i].si);
      tick();
      chk("valid_pulse", bus.rd_valid, 0);
      last_exp = vecs[i].data;
      repeat (2) tick();
    end

    // DREQ stuck low
    bus.DREQ = 1'b0;
    st0 = stray;
    req(4'h4, rc);
    te = -1;
    lows = 0;
    vcnt = 0;
    for (int i = 0; i < 1100 && te < 0; i++) begin
      tick();
      if (bus.XCS !== 1'b1) lows++;
      if (bus.rd_valid === 1'b1) vcnt++;
      if (bus.timeout_err === 1'b1) te = cyc;
    end
    chk("tmo_lat", te - rc, 1000);
    chk("tmo_busy", bus.busy, 0);
    chk("tmo_xcs", lows, 0);
    chk("tmo_sck", stray - st0, 0);
    chk("tmo_data", bus.rd_data, last_exp);
    chk("tmo_novalid", vcnt, 0);
    tick();
    chk("tmo_pulse", bus.timeout_err, 0);
    bus.DREQ = 1'b1;
    repeat (2) tick();

    // back-to-back with rd_req held high
    mem[15] = 16'hFFFF;
    sb_q.push_back(16'hFFFF);
    sb_q.push_back(16'h0000);
    bus.rd_addr = 4'hF;
    bus.rd_req  = 1'b1;
    tick();
    rc = cyc;
    do_frame(rc, 1, 16'h030F);
    mem[15] = 16'h0000;
    tick();
    chk("b2b_pulse", bus.rd_valid, 0);
    chk("b2b_accept", bus.busy, 1);
    rc = cyc;
    do_frame(rc, 1, 16'h030F);
    bus.rd_req = 1'b0;
    tick();
    chk("b2b_pulse2", bus.rd_valid, 0);
    tick();
    chk("b2b_idle", bus.busy, 0);
    last_exp = 16'h0000;

    // reset in the middle of SHIFT_IN
    mem[4] = 16'h1234;
    req(4'h4, rc);
    while (cyc < rc + 44) tick();
    chk("mid_busy", bus.busy, 1);
    chk("mid_xcs", bus.XCS, 0);
    rst = 1'b0;
    tick();
    chk("mr_xcs", bus.XCS, 1);
    chk("mr_sck", bus.SCK, 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_data", bus.rd_data, 0);
    chk("mr_valid", bus.rd_valid, 0);
    rst = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (bus.rd_valid !== 1'b0) vcnt++;
    end
    chk("mr_novalid", vcnt, 0);
    mem[4] = 16'h4321;
    sb_q.push_back(16'h4321);
    req(4'h4, rc);
    do_frame(rc, 1, 16'h0304);
    tick();
    chk("mr_pulse", bus.rd_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
